canv_disp_ctrl: RTL

Canvas display controller: owns the configuration feeding the canvas display AGU. Software writes staging registers, then requests a commit or a buffer flip. The controller applies them atomically on the next `frame_start`, so the AGU never sees a half-updated window, scale or base within a frame. It sits in the pixel clock domain, between the CPU register bridge and `canv_disp_agu`.

---
 rtl/canv_pkg.sv | 51 +++++
 rtl/canv_req_sync.sv | 45 ++++
 rtl/canv_disp_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/canv_pkg.sv
// Shared definitions for the canvas display path (controller and AGU).
// Holds the register map, CTRL bit positions, the pending-request state
// type, and helpers for packed {y,x} coordinate pairs.
package canv_pkg;

  // Coordinate width assumed by the {y,x} helpers below.
  localparam int CANV_CORDW = 16;

  // Staging register select values. Select 7 is reserved and ignored.
  localparam logic [2:0] CANV_REG_BASE_A    = 3'd0;
  localparam logic [2:0] CANV_REG_BASE_B    = 3'd1;
  localparam logic [2:0] CANV_REG_SHIFT     = 3'd2;
  localparam logic [2:0] CANV_REG_WIN_START = 3'd3;
  localparam logic [2:0] CANV_REG_WIN_END   = 3'd4;
  localparam logic [2:0] CANV_REG_SCALE     = 3'd5;
  localparam logic [2:0] CANV_REG_CTRL      = 3'd6;

  // CTRL write bits.
  localparam int CANV_CTRL_COMMIT = 0;
  localparam int CANV_CTRL_FLIP   = 1;
  localparam int CANV_CTRL_EN     = 2;

  // Per-request pending state.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_PEND = 1'b1
  } canv_req_state_e;

  // Pack a signed y and x into a {y,x} word.
  function automatic logic [2*CANV_CORDW-1:0] canv_yx(
    input logic signed [CANV_CORDW-1:0] y,
    input logic signed [CANV_CORDW-1:0] x
  );
    return {y, x};
  endfunction

  // Extract y from a {y,x} word.
  function automatic logic signed [CANV_CORDW-1:0] canv_y(
    input logic [2*CANV_CORDW-1:0] yx
  );
    return yx[2*CANV_CORDW-1:CANV_CORDW];
  endfunction

  // Extract x from a {y,x} word.
  function automatic logic signed [CANV_CORDW-1:0] canv_x(
    input logic [2*CANV_CORDW-1:0] yx
  );
    return yx[CANV_CORDW-1:0];
  endfunction

endpackage

// File: rtl/canv_req_sync.sv
// Pending-flag cell for one frame-synchronised request.
// Ports:
//   i_clk   - pixel clock
//   i_rst   - asynchronous active-high reset
//   i_req   - request strobe (CTRL write with this request's bit set)
//   i_apply - frame start; clears a pending request
//   o_pend  - request is pending
// A request arriving in the same cycle as the apply keeps the flag set, so
// it is serviced on the following frame instead of being lost.
module canv_req_sync
  import canv_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_apply,
  output logic o_pend
);

  canv_req_state_e r_state;
  canv_req_state_e w_state_nxt;

  // State register; reset discards any pending request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= REQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: set wins over clear so a request written during the apply
  // cycle survives for the next frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ_IDLE: if (i_req) w_state_nxt = REQ_PEND;
      REQ_PEND: if (i_apply && !i_req) w_state_nxt = REQ_IDLE;
      default:  w_state_nxt = REQ_IDLE;
    endcase
  end

  assign o_pend = (r_state == REQ_PEND);

endmodule

// File: rtl/canv_disp_ctrl.sv
// Canvas display controller: staging registers written by software are
// transferred to the live AGU configuration atomically on frame_start.
// Ports:
//   clk_pix, rst_pix          - pixel clock, async active-high reset
//   frame_start               - one-cycle pulse in vertical blanking
//   reg_we/reg_sel/reg_data   - staging register write port
//   addr_base, addr_shift     - active buffer base and address shift to AGU
//   win_start/win_end/scale   - {y,x} window and scale to AGU
//   canv_en, buf_sel          - canvas enable and active buffer (0=A, 1=B)
//   commit_pend, flip_pend    - requests waiting for the next frame_start
//   applied                   - pulse in the cycle new values become visible
//   frame_cnt                 - frames since reset (wraps)
module canv_disp_ctrl
  import canv_pkg::*;
#(
  parameter int CORDW  = 16,
  parameter int WORD   = 32,
  parameter int ADDRW  = 20,
  parameter int SHIFTW = 3,
  parameter int FCNTW  = 16
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix,
  input  logic                 frame_start,
  input  logic                 reg_we,
  input  logic [2:0]           reg_sel,
  input  logic [WORD-1:0]      reg_data,
  output logic [ADDRW-1:0]     addr_base,
  output logic [SHIFTW-1:0]    addr_shift,
  output logic [2*CORDW-1:0]   win_start,
  output logic [2*CORDW-1:0]   win_end,
  output logic [2*CORDW-1:0]   scale,
  output logic                 canv_en,
  output logic                 buf_sel,
  output logic                 commit_pend,
  output logic                 flip_pend,
  output logic                 applied,
  output logic [FCNTW-1:0]     frame_cnt
);

  logic [ADDRW-1:0]   r_stg_base_a, r_stg_base_b, r_live_base_a, r_live_base_b;
  logic [SHIFTW-1:0]  r_stg_shift, r_live_shift;
  logic [2*CORDW-1:0] r_stg_win_start, r_stg_win_end, r_stg_scale;
  logic [2*CORDW-1:0] r_live_win_start, r_live_win_end, r_live_scale;
  logic               r_stg_canv_en, r_live_canv_en;
  logic               r_buf_sel, r_applied;
  logic [FCNTW-1:0]   r_frame_cnt;

  logic w_ctrl_we, w_commit_req, w_flip_req, w_do_commit, w_do_flip;

  assign w_ctrl_we    = reg_we && (reg_sel == CANV_REG_CTRL);
  assign w_commit_req = w_ctrl_we && reg_data[CANV_CTRL_COMMIT];
  assign w_flip_req   = w_ctrl_we && reg_data[CANV_CTRL_FLIP];

  canv_req_sync u_commit_req (
    .i_clk   (clk_pix),
    .i_rst   (rst_pix),
    .i_req   (w_commit_req),
    .i_apply (frame_start),
    .o_pend  (commit_pend)
  );

  canv_req_sync u_flip_req (
    .i_clk   (clk_pix),
    .i_rst   (rst_pix),
    .i_req   (w_flip_req),
    .i_apply (frame_start),
    .o_pend  (flip_pend)
  );

  // Only a request that was already pending before this frame_start applies.
  assign w_do_commit = frame_start && commit_pend;
  assign w_do_flip   = frame_start && flip_pend;

  // Staging registers take the low bits of reg_data.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_stg_base_a    <= '0;
      r_stg_base_b    <= '0;
      r_stg_shift     <= '0;
      r_stg_win_start <= '0;
      r_stg_win_end   <= '0;
      r_stg_scale     <= '0;
      r_stg_canv_en   <= 1'b0;
    end else if (reg_we) begin
      case (reg_sel)
        CANV_REG_BASE_A:    r_stg_base_a    <= reg_data[ADDRW-1:0];
        CANV_REG_BASE_B:    r_stg_base_b    <= reg_data[ADDRW-1:0];
        CANV_REG_SHIFT:     r_stg_shift     <= reg_data[SHIFTW-1:0];
        CANV_REG_WIN_START: r_stg_win_start <= reg_data[2*CORDW-1:0];
        CANV_REG_WIN_END:   r_stg_win_end   <= reg_data[2*CORDW-1:0];
        CANV_REG_SCALE:     r_stg_scale     <= reg_data[2*CORDW-1:0];
        CANV_REG_CTRL:      r_stg_canv_en   <= reg_data[CANV_CTRL_EN];
        default: ;
      endcase
    end
  end

  // Live configuration: the commit reads staging before any same-cycle write
  // lands, because both are non-blocking updates on the same edge.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_live_base_a    <= '0;
      r_live_base_b    <= '0;
      r_live_shift     <= '0;
      r_live_win_start <= '0;
      r_live_win_end   <= '0;
      r_live_scale     <= '0;
      r_live_canv_en   <= 1'b0;
      r_buf_sel        <= 1'b0;
    end else begin
      if (w_do_commit) begin
        r_live_base_a    <= r_stg_base_a;
        r_live_base_b    <= r_stg_base_b;
        r_live_shift     <= r_stg_shift;
        r_live_win_start <= r_stg_win_start;
        r_live_win_end   <= r_stg_win_end;
        r_live_scale     <= r_stg_scale;
        r_live_canv_en   <= r_stg_canv_en;
      end
      if (w_do_flip) begin
        r_buf_sel <= ~r_buf_sel;
      end
    end
  end

  // Frame counter and the apply indication.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_frame_cnt <= '0;
      r_applied   <= 1'b0;
    end else begin
      r_applied <= w_do_commit || w_do_flip;
      if (frame_start) begin
        r_frame_cnt <= r_frame_cnt + FCNTW'(1);
      end
    end
  end

  // Base mux sits after the live registers so a simultaneous commit and flip
  // shows the new buffer with the new bases in the same cycle.
  assign addr_base  = r_buf_sel ? r_live_base_b : r_live_base_a;
  assign addr_shift = r_live_shift;
  assign win_start  = r_live_win_start;
  assign win_end    = r_live_win_end;
  assign scale      = r_live_scale;
  assign canv_en    = r_live_canv_en;
  assign buf_sel    = r_buf_sel;
  assign applied    = r_applied;
  assign frame_cnt  = r_frame_cnt;

endmodule
